// File: rtl/vdp_pkg.sv
// Shared VDP definitions: VRAM geometry, CPU-port FSM encoding and access owner tags.
package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_RD   = 2'd1,
    CPU_ACK  = 2'd2
  } cpu_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_VID = 1'b1;

  function automatic logic is_saturated(input logic [15:0] value);
    return &value;
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scan-out has absolute priority, the CPU port
// uses a req/ack handshake and is served in cycles the video fetch leaves idle.
module vram_arbiter
  import vdp_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int STAT_W = 16
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  cpu_state_e        state_r;
  logic              cpu_grant_s;
  logic              stall_hit_s;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] wdata_hold_r;
  logic              acc_valid_r;
  logic              acc_owner_r;
  logic [DATA_W-1:0] vid_data_r;
  logic              vid_valid_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic              cpu_ack_r;
  logic [STAT_W-1:0] stall_r;

  assign cpu_grant_s = !vid_req && (state_r == CPU_IDLE) && cpu_req;
  assign stall_hit_s = (state_r == CPU_IDLE) && cpu_req && vid_req;

  // Grant mux: an idle cycle keeps the bus parked on the last address/data.
  always_comb begin
    mem_addr  = addr_hold_r;
    mem_we    = 1'b0;
    mem_wdata = wdata_hold_r;
    if (vid_req) begin
      mem_addr = vid_addr;
    end else if (cpu_grant_s) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Remember the driven bus values so they can be held while nobody owns the RAM.
  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      addr_hold_r  <= '0;
      wdata_hold_r <= '0;
    end else begin
      addr_hold_r  <= mem_addr;
      wdata_hold_r <= mem_wdata;
    end
  end

  // Owner tag rides alongside each access so only video reads raise vid_valid.
  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      acc_valid_r <= 1'b0;
      acc_owner_r <= OWNER_CPU;
      vid_valid_r <= 1'b0;
      vid_data_r  <= '0;
    end else begin
      acc_valid_r <= vid_req || cpu_grant_s;
      acc_owner_r <= vid_req ? OWNER_VID : OWNER_CPU;
      vid_valid_r <= acc_valid_r && (acc_owner_r == OWNER_VID);
      if (acc_valid_r && (acc_owner_r == OWNER_VID)) begin
        vid_data_r <= mem_rdata;
      end else begin
        vid_data_r <= vid_data_r;
      end
    end
  end

  // CPU port FSM: writes complete at the grant edge, reads need one RAM latency cycle.
  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      state_r     <= CPU_IDLE;
      cpu_ack_r   <= 1'b0;
      cpu_rdata_r <= '0;
    end else begin
      cpu_ack_r <= 1'b0;
      case (state_r)
        CPU_IDLE: begin
          if (cpu_grant_s && cpu_we) begin
            state_r   <= CPU_ACK;
            cpu_ack_r <= 1'b1;
          end else if (cpu_grant_s) begin
            state_r <= CPU_RD;
          end else begin
            state_r <= CPU_IDLE;
          end
        end
        CPU_RD: begin
          cpu_rdata_r <= mem_rdata;
          cpu_ack_r   <= 1'b1;
          state_r     <= CPU_ACK;
        end
        CPU_ACK: begin
          state_r <= CPU_IDLE;
        end
        default: begin
          state_r <= CPU_IDLE;
        end
      endcase
    end
  end

  // Saturating count of cycles the CPU was locked out by video; clear has priority.
  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      stall_r <= '0;
    end else if (stat_clr) begin
      stall_r <= '0;
    end else if (stall_hit_s && !(&stall_r)) begin
      stall_r <= stall_r + STAT_W'(1);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign vid_data  = vid_data_r;
  assign vid_valid = vid_valid_r;
  assign cpu_rdata = cpu_rdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign cpu_stall = stall_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM model.
module tb_vram_arbiter;

  logic        pxclk;
  logic        reset;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        stat_clr;
  logic [15:0] cpu_stall;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  vram [0:16383];
  int          nvec;
  int          nerr;

  vram_arbiter dut (
    .pxclk     (pxclk),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .stat_clr  (stat_clr),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial pxclk = 1'b0;
  always #5 pxclk = ~pxclk;

  always @(posedge pxclk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  function automatic logic [7:0] vexp(input logic [13:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pxclk);
    #1;
  endtask

  task automatic cpu_write(input logic [13:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    chk("wr_grant_we", 32'(mem_we), 32'd1);
    chk("wr_grant_addr", 32'(mem_addr), 32'(a));
    chk("wr_grant_data", 32'(mem_wdata), 32'(d));
    cyc();
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();
    chk("wr_ack_drop", 32'(cpu_ack), 32'd0);
  endtask

  task automatic cpu_read(input logic [13:0] a, input logic [7:0] e);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    chk("rd_grant_addr", 32'(mem_addr), 32'(a));
    chk("rd_grant_we", 32'(mem_we), 32'd0);
    cyc();
    chk("rd_ack_early", 32'(cpu_ack), 32'd0);
    cyc();
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    chk("rd_data", 32'(cpu_rdata), 32'(e));
    cpu_req = 1'b0;
    cyc();
    chk("rd_ack_drop", 32'(cpu_ack), 32'd0);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    for (int i = 0; i < 16384; i++) vram[i] = vexp(14'(i));
    mem_rdata = 8'h00;
    reset = 1'b1; vid_req = 1'b0; vid_addr = 14'h0000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0000; cpu_wdata = 8'h00;
    stat_clr = 1'b0;
    #1;
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_vid_data", 32'(vid_data), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // 1: write then read back, no video
    cpu_write(14'h1234, 8'hA5);
    cpu_read(14'h1234, 8'hA5);

    // 2: 8-cycle video burst while the CPU waits
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0040;
    for (int i = 0; i < 8; i++) begin
      vid_req = 1'b1; vid_addr = 14'h0100 + 14'(i);
      #1;
      chk("t2_mem_addr", 32'(mem_addr), 32'h100 + 32'(i));
      chk("t2_mem_we", 32'(mem_we), 32'd0);
      cyc();
      chk("t2_no_ack", 32'(cpu_ack), 32'd0);
      if (i >= 1) begin
        chk("t2_vid_valid", 32'(vid_valid), 32'd1);
        chk("t2_vid_data", 32'(vid_data), 32'(vexp(14'h0100 + 14'(i - 1))));
      end else begin
        chk("t2_vid_valid0", 32'(vid_valid), 32'd0);
      end
    end
    vid_req = 1'b0;
    #1;
    chk("t2_cpu_grant", 32'(mem_addr), 32'h0040);
    chk("t2_stall", 32'(cpu_stall), 32'd8);
    cyc();
    chk("t2_last_valid", 32'(vid_valid), 32'd1);
    chk("t2_last_data", 32'(vid_data), 32'(vexp(14'h0107)));
    chk("t2_rd_no_ack", 32'(cpu_ack), 32'd0);
    cyc();
    chk("t2_valid_end", 32'(vid_valid), 32'd0);
    chk("t2_ack", 32'(cpu_ack), 32'd1);
    chk("t2_rdata", 32'(cpu_rdata), 32'h1A);
    cpu_req = 1'b0;
    cyc();

    // 3: video steals the RAM during RD/ACK, no cross-talk
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0033;
    cyc();
    vid_req = 1'b1; vid_addr = 14'h0200;
    #1;
    chk("t3_vid_addr", 32'(mem_addr), 32'h0200);
    cyc();
    chk("t3_ack", 32'(cpu_ack), 32'd1);
    chk("t3_rdata", 32'(cpu_rdata), 32'h69);
    chk("t3_no_valid", 32'(vid_valid), 32'd0);
    cpu_req = 1'b0; vid_addr = 14'h0207;
    cyc();
    vid_req = 1'b0;
    chk("t3_valid0", 32'(vid_valid), 32'd1);
    chk("t3_data0", 32'(vid_data), 32'h5A);
    chk("t3_ack_drop", 32'(cpu_ack), 32'd0);
    cyc();
    chk("t3_valid1", 32'(vid_valid), 32'd1);
    chk("t3_data1", 32'(vid_data), 32'h5D);
    chk("t3_rdata_hold", 32'(cpu_rdata), 32'h69);
    cyc();
    chk("t3_valid_end", 32'(vid_valid), 32'd0);
    chk("t3_stall", 32'(cpu_stall), 32'd8);

    // 4: stall counter saturation and clear priority
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0040;
    vid_req = 1'b1; vid_addr = 14'h0010; stat_clr = 1'b1;
    cyc();
    chk("t4_clr_wins", 32'(cpu_stall), 32'd0);
    stat_clr = 1'b0;
    repeat (65534) cyc();
    chk("t4_fffe", 32'(cpu_stall), 32'hFFFE);
    cyc();
    chk("t4_ffff", 32'(cpu_stall), 32'hFFFF);
    cyc();
    chk("t4_sat1", 32'(cpu_stall), 32'hFFFF);
    cyc();
    chk("t4_sat2", 32'(cpu_stall), 32'hFFFF);
    chk("t4_no_ack", 32'(cpu_ack), 32'd0);
    stat_clr = 1'b1;
    cyc();
    chk("t4_clr", 32'(cpu_stall), 32'd0);
    stat_clr = 1'b0; vid_req = 1'b0;
    cyc();
    cyc();
    chk("t4_ack", 32'(cpu_ack), 32'd1);
    chk("t4_rdata", 32'(cpu_rdata), 32'h1A);
    cpu_req = 1'b0;
    cyc();

    // 5: reset asserted while the CPU read is in RD
    vid_req = 1'b1; vid_addr = 14'h0300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0033;
    cyc();
    vid_req = 1'b0;
    cyc();
    chk("t5_pre_valid", 32'(vid_valid), 32'd1);
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("t5_vid_valid", 32'(vid_valid), 32'd0);
    chk("t5_vid_data", 32'(vid_data), 32'd0);
    chk("t5_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("t5_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("t5_stall", 32'(cpu_stall), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_mem_we", 32'(mem_we), 32'd0);
    chk("t5_mem_wdata", 32'(mem_wdata), 32'd0);
    cyc();
    chk("t5_ack_in_rst", 32'(cpu_ack), 32'd0);
    reset = 1'b0;
    cyc();
    chk("t5_ack_after", 32'(cpu_ack), 32'd0);
    chk("t5_valid_after", 32'(vid_valid), 32'd0);
    cyc();
    chk("t5_ack_after2", 32'(cpu_ack), 32'd0);
    chk("t5_valid_after2", 32'(vid_valid), 32'd0);
    cpu_read(14'h0033, 8'h69);

    // 6: request held through ACK must not cause a second access
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0500; cpu_wdata = 8'h3C;
    #1;
    chk("t6_grant_we", 32'(mem_we), 32'd1);
    cyc();
    chk("t6_ack", 32'(cpu_ack), 32'd1);
    chk("t6_no_access", 32'(mem_we), 32'd0);
    cyc();
    chk("t6_ack_drop", 32'(cpu_ack), 32'd0);
    cpu_addr = 14'h0501; cpu_wdata = 8'hC3;
    #1;
    chk("t6_new_grant_we", 32'(mem_we), 32'd1);
    chk("t6_new_grant_addr", 32'(mem_addr), 32'h0501);
    cyc();
    chk("t6_new_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();
    cpu_read(14'h0500, 8'h3C);
    cpu_read(14'h0501, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
